// File: rtl/clock_set_sequencer_pkg.sv
// Shared widths, limits and state encoding for the clock time-setting front end.
package clock_set_sequencer_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;

  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SET_H  = 2'd1,
    ST_SET_M  = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

endpackage

// File: rtl/clock_fmt_conv.sv
// Combinational 24-h to 12-h hour converter; pass-through when fmt12 is low.
module clock_fmt_conv
  import clock_set_sequencer_pkg::*;
(
  input  logic [HOUR_W-1:0] hours_24,
  input  logic              fmt12,
  output logic [HOUR_W-1:0] hours_disp,
  output logic              pm
);

  always_comb begin
    hours_disp = hours_24;
    pm         = 1'b0;
    if (fmt12) begin
      if (hours_24 == 5'd0) begin
        hours_disp = 5'd12;
      end else if (hours_24 >= 5'd13) begin
        hours_disp = hours_24 - 5'd12;
        pm         = 1'b1;
      end else if (hours_24 == 5'd12) begin
        pm = 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_set_sequencer.sv
// Time-setting sequencer: hour edit, minute edit, commit strobe, inactivity abort
// and 12/24-h display format ownership.
//
//   state     | meaning
//   ----------+--------------------------------------------------
//   ST_IDLE   | running; set starts an edit, mode toggles format
//   ST_SET_H  | editing hours with up/down
//   ST_SET_M  | editing minutes with up/down
//   ST_COMMIT | single cycle, propagate strobe with edited time
module clock_set_sequencer
  import clock_set_sequencer_pkg::*;
#(
  parameter int TIMEOUT_S = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_1hz,
  input  logic              pulsed_set,
  input  logic              pulsed_up,
  input  logic              pulsed_down,
  input  logic              pulsed_mode,
  input  logic [HOUR_W-1:0] cur_hours,
  input  logic [MIN_W-1:0]  cur_minutes,
  output logic [1:0]        current_state,
  output logic              set_enable,
  output logic              fmt12,
  output logic [HOUR_W-1:0] edit_hours,
  output logic [MIN_W-1:0]  edit_minutes,
  output logic [HOUR_W-1:0] disp_hours,
  output logic              disp_pm,
  output logic              propagate,
  output logic              timed_out
);

  localparam logic [5:0] TO_LAST = 6'(TIMEOUT_S - 1);

  state_t            state;
  logic [5:0]        to_cnt;
  logic              press;
  logic [HOUR_W-1:0] disp_src;

  assign press = pulsed_up | pulsed_down;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_IDLE;
      fmt12        <= 1'b0;
      edit_hours   <= '0;
      edit_minutes <= '0;
      to_cnt       <= '0;
      propagate    <= 1'b0;
      timed_out    <= 1'b0;
    end else begin
      propagate <= 1'b0;
      timed_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pulsed_mode) fmt12 <= ~fmt12;
          if (pulsed_set) begin
            state        <= ST_SET_H;
            edit_hours   <= (cur_hours > HOUR_MAX) ? '0 : cur_hours;
            edit_minutes <= (cur_minutes > MIN_MAX) ? '0 : cur_minutes;
            to_cnt       <= '0;
          end
        end
        ST_SET_H, ST_SET_M: begin
          if (pulsed_set) begin
            to_cnt <= '0;
            if (state == ST_SET_H) begin
              state <= ST_SET_M;
            end else begin
              state     <= ST_COMMIT;
              propagate <= 1'b1;
            end
          end else if (press) begin
            // up and down together still count as activity but cancel out
            to_cnt <= '0;
            if (pulsed_up != pulsed_down) begin
              if (state == ST_SET_H) begin
                if (pulsed_up)
                  edit_hours <= (edit_hours == HOUR_MAX) ? '0 : edit_hours + 5'd1;
                else
                  edit_hours <= (edit_hours == 5'd0) ? HOUR_MAX : edit_hours - 5'd1;
              end else begin
                if (pulsed_up)
                  edit_minutes <= (edit_minutes == MIN_MAX) ? '0 : edit_minutes + 6'd1;
                else
                  edit_minutes <= (edit_minutes == 6'd0) ? MIN_MAX : edit_minutes - 6'd1;
              end
            end
          end else if (tick_1hz) begin
            if (to_cnt == TO_LAST) begin
              state     <= ST_IDLE;
              timed_out <= 1'b1;
              to_cnt    <= '0;
            end else begin
              to_cnt <= to_cnt + 6'd1;
            end
          end
        end
        ST_COMMIT: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  assign current_state = state;
  assign set_enable    = (state == ST_SET_H) || (state == ST_SET_M);
  assign disp_src      = set_enable ? edit_hours : cur_hours;

  clock_fmt_conv u_fmt_conv (
    .hours_24   (disp_src),
    .fmt12      (fmt12),
    .hours_disp (disp_hours),
    .pm         (disp_pm)
  );

endmodule

// File: tb/tb_clock_set_sequencer.sv
// Randomized and directed bench for clock_set_sequencer against a behavioural model.
module tb_clock_set_sequencer;

  localparam int T_S = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick_1hz = 1'b0, pulsed_set = 1'b0, pulsed_up = 1'b0;
  logic       pulsed_down = 1'b0, pulsed_mode = 1'b0;
  logic [4:0] cur_hours = 5'd0;
  logic [5:0] cur_minutes = 6'd0;
  logic [1:0] current_state;
  logic       set_enable, fmt12, disp_pm, propagate, timed_out;
  logic [4:0] edit_hours, disp_hours;
  logic [5:0] edit_minutes;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // model: 0 idle, 1 hour edit, 2 minute edit, 3 commit
  int m_st = 0, m_fmt = 0, m_eh = 0, m_em = 0, m_cnt = 0, m_prop = 0, m_to = 0;

  clock_set_sequencer #(.TIMEOUT_S(T_S)) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .pulsed_set(pulsed_set),
    .pulsed_up(pulsed_up), .pulsed_down(pulsed_down), .pulsed_mode(pulsed_mode),
    .cur_hours(cur_hours), .cur_minutes(cur_minutes), .current_state(current_state),
    .set_enable(set_enable), .fmt12(fmt12), .edit_hours(edit_hours),
    .edit_minutes(edit_minutes), .disp_hours(disp_hours), .disp_pm(disp_pm),
    .propagate(propagate), .timed_out(timed_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    m_prop = 0;
    m_to   = 0;
    if (!reset) begin
      m_st = 0; m_fmt = 0; m_eh = 0; m_em = 0; m_cnt = 0;
    end else if (m_st == 0) begin
      if (pulsed_mode) m_fmt = 1 - m_fmt;
      if (pulsed_set) begin
        m_st  = 1;
        m_eh  = (cur_hours > 23) ? 0 : int'(cur_hours);
        m_em  = (cur_minutes > 59) ? 0 : int'(cur_minutes);
        m_cnt = 0;
      end
    end else if (m_st == 3) begin
      m_st = 0;
    end else begin
      if (pulsed_set) begin
        m_cnt = 0;
        m_st  = m_st + 1;
        if (m_st == 3) m_prop = 1;
      end else if (pulsed_up || pulsed_down) begin
        m_cnt = 0;
        if (pulsed_up && !pulsed_down) begin
          if (m_st == 1) m_eh = (m_eh + 1) % 24;
          else           m_em = (m_em + 1) % 60;
        end else if (pulsed_down && !pulsed_up) begin
          if (m_st == 1) m_eh = (m_eh + 23) % 24;
          else           m_em = (m_em + 59) % 60;
        end
      end else if (tick_1hz) begin
        if (m_cnt == T_S - 1) begin
          m_st = 0; m_to = 1; m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      int src, eh, epm;
      src = (m_st == 1 || m_st == 2) ? m_eh : int'(cur_hours);
      eh  = src;
      epm = 0;
      if (m_fmt == 1) begin
        if (src == 0)       eh = 12;
        else if (src == 12) epm = 1;
        else if (src > 12)  begin eh = src - 12; epm = 1; end
      end
      chk("state", int'(current_state), m_st);
      chk("set_enable", int'(set_enable), (m_st == 1 || m_st == 2) ? 1 : 0);
      chk("fmt12", int'(fmt12), m_fmt);
      chk("edit_hours", int'(edit_hours), m_eh);
      chk("edit_minutes", int'(edit_minutes), m_em);
      chk("disp_hours", int'(disp_hours), eh);
      chk("disp_pm", int'(disp_pm), epm);
      chk("propagate", int'(propagate), m_prop);
      chk("timed_out", int'(timed_out), m_to);
    end
  end

  task automatic cycle(input bit s, input bit u, input bit d, input bit m, input bit t);
    pulsed_set = s; pulsed_up = u; pulsed_down = d; pulsed_mode = m; tick_1hz = t;
    @(posedge clk);
    model_step();
    #1;
    pulsed_set = 0; pulsed_up = 0; pulsed_down = 0; pulsed_mode = 0; tick_1hz = 0;
  endtask

  initial begin
    reset = 0;
    cycle(0, 0, 0, 0, 0);
    chk_en = 1;
    chk("rst_state", int'(current_state), 0);
    chk("rst_edit_h", int'(edit_hours), 0);
    reset = 1;

    // basic edit and commit
    cur_hours = 5'd13; cur_minutes = 6'd45;
    cycle(1, 0, 0, 0, 0);
    chk("load_state", int'(current_state), 1);
    chk("load_h", int'(edit_hours), 13);
    chk("load_m", int'(edit_minutes), 45);
    for (int i = 0; i < 11; i++) cycle(0, 1, 0, 0, 0);
    chk("hour_wrap", int'(edit_hours), 0);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    chk("min_dec", int'(edit_minutes), 44);
    cycle(1, 0, 0, 0, 0);
    chk("commit_prop", int'(propagate), 1);
    chk("commit_state", int'(current_state), 3);
    chk("commit_h", int'(edit_hours), 0);
    chk("commit_m", int'(edit_minutes), 44);
    cycle(0, 0, 0, 0, 0);
    chk("post_commit_prop", int'(propagate), 0);
    chk("post_commit_state", int'(current_state), 0);

    // minute wrap without hour carry
    cur_hours = 5'd10; cur_minutes = 6'd59;
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    chk("min_wrap_up", int'(edit_minutes), 0);
    chk("min_wrap_h", int'(edit_hours), 10);
    cycle(0, 0, 1, 0, 0);
    chk("min_wrap_dn", int'(edit_minutes), 59);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);

    // timeout, then press before final tick
    cur_hours = 5'd5; cur_minutes = 6'd0;
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    chk("pre_timeout_state", int'(current_state), 1);
    cycle(0, 0, 0, 0, 1);
    chk("timeout_state", int'(current_state), 0);
    chk("timeout_strobe", int'(timed_out), 1);
    chk("timeout_noprop", int'(propagate), 0);
    chk("timeout_keep_h", int'(edit_hours), 5);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    chk("press_saves_state", int'(current_state), 1);
    chk("press_saves_to", int'(timed_out), 0);
    cycle(0, 1, 0, 0, 1);
    chk("press_on_tick", int'(edit_hours), 7);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);

    // display format
    cycle(0, 0, 0, 1, 0);
    chk("fmt_toggle", int'(fmt12), 1);
    cur_hours = 5'd0;  #1;
    chk("fmt_0_h", int'(disp_hours), 12);  chk("fmt_0_pm", int'(disp_pm), 0);
    cur_hours = 5'd12; #1;
    chk("fmt_12_h", int'(disp_hours), 12); chk("fmt_12_pm", int'(disp_pm), 1);
    cur_hours = 5'd23; #1;
    chk("fmt_23_h", int'(disp_hours), 11); chk("fmt_23_pm", int'(disp_pm), 1);
    cur_minutes = 6'd30;
    cycle(1, 0, 0, 0, 0);
    cur_hours = 5'd0;
    cycle(0, 0, 0, 1, 0);
    chk("fmt_in_edit", int'(fmt12), 1);
    chk("disp_edit_src", int'(disp_hours), 11);

    // simultaneous events
    cycle(1, 1, 0, 0, 0);
    chk("set_up_state", int'(current_state), 2);
    chk("set_up_h", int'(edit_hours), 23);
    cycle(0, 1, 1, 0, 0);
    chk("up_down_m", int'(edit_minutes), 30);

    // reset mid-edit
    reset = 0;
    cycle(0, 0, 0, 0, 0);
    reset = 1;
    chk("rst_mid_state", int'(current_state), 0);
    chk("rst_mid_fmt", int'(fmt12), 0);
    chk("rst_mid_m", int'(edit_minutes), 0);
    chk("rst_mid_prop", int'(propagate), 0);
    cycle(0, 0, 0, 0, 0);
    chk("rst_after_prop", int'(propagate), 0);

    // randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 3) == 0) begin
        cur_hours   = 5'($urandom_range(0, 31));
        cur_minutes = 6'($urandom_range(0, 63));
      end
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 2) == 0);
    end

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_set_sequencer.md
Name: clock_set_sequencer

Overview:
Front-end controller that drives time setting for the clock datapath (set logic plus running 24-h counter). It decodes the debounced set, up, down and mode pulses into an edit sequence: hour field, then minute field, then commit. On commit it issues a one-cycle propagate pulse with the edited time. It also owns the 12/24-h display-format selection and aborts an edit after an inactivity timeout.

Parameters:
TIMEOUT_S, 10, number of tick_1hz pulses without a button press before an edit is aborted (range 2..63).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
tick_1hz  input  1  one-cycle enable pulse, once per second, from the real-time divider
pulsed_set  input  1  one-cycle set/advance pulse
pulsed_up  input  1  one-cycle increment pulse
pulsed_down  input  1  one-cycle decrement pulse
pulsed_mode  input  1  one-cycle 12/24-h toggle pulse
cur_hours  input  5  running hours, 0..23
cur_minutes  input  6  running minutes, 0..59
current_state  output  2  FSM state encoding
set_enable  output  1  high in SET_H and SET_M
fmt12  output  1  1 = 12-h display format
edit_hours  output  5  edited hours, 24-h form, 0..23
edit_minutes  output  6  edited minutes, 0..59
disp_hours  output  5  display hours (1..12 when fmt12=1, else 0..23)
disp_pm  output  1  PM flag, valid only when fmt12=1, else 0
propagate  output  1  one-cycle commit strobe
timed_out  output  1  one-cycle abort strobe

Behaviour:
- Clock and reset:
  - All state updates on the rising edge of clk.
  - reset=0 sampled at an edge forces: state IDLE, fmt12=0, edit_hours=0, edit_minutes=0, timeout counter=0, propagate=0, timed_out=0.
  - Reset mid-edit never produces propagate.
- States (2'd0..2'd3): IDLE, SET_H, SET_M, COMMIT.
- IDLE:
  - pulsed_set -> SET_H. On the same edge, edit_hours and edit_minutes load from cur_*. Out-of-range values are clamped to 0 (hours >23, minutes >59).
  - pulsed_mode toggles fmt12. pulsed_up and pulsed_down are ignored.
- SET_H:
  - up: hours +1, wrapping 23->0. down: hours -1, wrapping 0->23.
  - pulsed_set -> SET_M.
- SET_M:
  - up: minutes +1, wrapping 59->0. down: minutes -1, wrapping 0->59.
  - Minute wrap never carries into hours.
  - pulsed_set -> COMMIT.
- COMMIT: lasts exactly one cycle, then IDLE. propagate=1 only in this cycle. edit_* are stable during and after COMMIT.
- Priority on simultaneous events:
  - reset overrides everything.
  - pulsed_set overrides up/down in the same cycle.
  - up and down together leave the field unchanged.
  - pulsed_mode is ignored outside IDLE.
- Timeout:
  - The counter clears on entry to SET_H and on any set/up/down pulse. It increments on tick_1hz while in SET_H or SET_M.
  - When tick_1hz arrives with counter = TIMEOUT_S-1: next state IDLE, timed_out=1 for one cycle, no propagate, edit_* retained.
  - A button press in the same cycle as the expiring tick wins: the press is applied and the counter clears.
- Latency: a button pulse in cycle n is visible on state and edit outputs in cycle n+1. propagate appears one cycle after the final set.
- Display (combinational):
  - Source is edit_hours in SET_H and SET_M, cur_hours otherwise.
  - fmt12=1: 0->12 with pm=0; 1..11 -> same with pm=0; 12 -> 12 with pm=1; 13..23 -> h-12 with pm=1.
  - fmt12=0: pass-through, pm=0.

Decomposition:
- Shared package: state encodings, HOUR_MAX=23, MIN_MAX=59, HOUR_W=5, MIN_W=6.
- One sub-module: clock_fmt_conv, the combinational 24->12-h converter. It is reusable by the display driver.

Test Plan:
1. Basic edit and commit:
   - Stimulus: reset, cur=13:45, set; up x11; set; down x1; set.
   - Required: SET_H shows 13:45; hours wrap 23->0 reaching 00; minutes 44; propagate high exactly 1 cycle with edit 00:44, then IDLE.
2. Minute wrap: edit minutes 59, up -> 00 with hours unchanged; down -> 59.
3. Timeout (TIMEOUT_S=3):
   - Enter SET_H, 3 ticks with no press -> IDLE with timed_out pulse and no propagate.
   - Repeat with an up press between tick 2 and tick 3 -> stays in SET_H.
4. Format:
   - mode pulse in IDLE -> fmt12=1. cur 0 -> 12 AM; 12 -> 12 PM; 23 -> 11 PM.
   - mode pulse in SET_H -> fmt12 unchanged.
5. Simultaneous events: set+up in SET_H -> SET_M with hours unchanged; up+down in SET_M -> no change.
6. Reset mid-edit: reset=0 in SET_M -> next cycle IDLE with all outputs at reset values, and no propagate at any point.
